// File: rtl/runtime_cfg_unit_pkg.sv
// Shared types and constants for the runtime configuration register block:
// FSM states, address map offsets, control bits and register indices.
package runtime_cfg_unit_pkg;

    typedef enum logic [1:0] {
        CFG_IDLE    = 2'd0,
        CFG_QUIESCE = 2'd1,
        CFG_APPLY   = 2'd2,
        CFG_RELEASE = 2'd3
    } cfg_state_t;

    localparam int CFG_N_REGS = 8;
    localparam int CFG_EPOCH_W = 8;

    // Special registers sit directly above the shadow bank
    localparam int CFG_CTRL_OFS = 0;
    localparam int CFG_STATUS_OFS = 1;
    localparam int CFG_VERSION_OFS = 2;

    localparam int CFG_CTRL_ADDR = CFG_N_REGS + CFG_CTRL_OFS;
    localparam int CFG_STATUS_ADDR = CFG_N_REGS + CFG_STATUS_OFS;
    localparam int CFG_VERSION_ADDR = CFG_N_REGS + CFG_VERSION_OFS;

    localparam int CFG_CTRL_COMMIT = 0;
    localparam int CFG_CTRL_ABORT = 1;
    localparam int CFG_CTRL_CLR_ERR = 2;

    typedef struct packed {
        logic                   error;
        cfg_state_t             state;
        logic [CFG_EPOCH_W-1:0] epoch;
    } cfg_status_t;

    localparam int CFG_REG_CQ_SIZE = 0;
    localparam int CFG_REG_SPILL_HI = 1;
    localparam int CFG_REG_SPILL_LO = 2;
    localparam int CFG_REG_LOG_MASK = 3;
    localparam int CFG_REG_TRACE_SEL = 4;
    localparam int CFG_REG_PRIO = 5;
    localparam int CFG_REG_RSVD6 = 6;
    localparam int CFG_REG_RSVD7 = 7;

endpackage

// File: rtl/cfg_quiesce_ctr.sv
// Quiescence monitor: reports two consecutive all-idle cycles and a
// saturating timeout while enabled.
module cfg_quiesce_ctr #(
    parameter int N_TILES = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_TILES-1:0] tile_idle,
    input  logic               en,
    input  logic               clr,
    output logic               stable,
    output logic               timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic          all_idle;
    logic          seen_q;
    logic          seen_d;
    logic [TW-1:0] tmo_q;
    logic [TW-1:0] tmo_d;

    always_comb begin
        all_idle = &tile_idle;
        seen_d = seen_q;
        tmo_d = tmo_q;
        if (clr || !en) begin
            seen_d = 1'b0;
            tmo_d = '0;
        end else begin
            seen_d = all_idle;
            if (tmo_q != TW'(TIMEOUT)) begin
                tmo_d = tmo_q + 1'b1;
            end
        end
        // seen_q covers the previous cycle, all_idle the current one
        stable = en && all_idle && seen_q;
        timeout = en && (tmo_q == TW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_q <= 1'b0;
            tmo_q <= '0;
        end else begin
            seen_q <= seen_d;
            tmo_q <= tmo_d;
        end
    end

endmodule

// File: rtl/runtime_cfg_unit.sv
// Runtime configuration block: host-written shadow set committed atomically
// into the active set after all tiles quiesce.
module runtime_cfg_unit
    import runtime_cfg_unit_pkg::*;
#(
    parameter int N_TILES = 1,
    parameter int N_REGS = 8,
    parameter int CFG_WIDTH = 32,
    parameter int EPOCH_WIDTH = 8,
    parameter int QUIESCE_TIMEOUT = 1024,
    parameter int VERSION = 10,
    parameter int ADDR_W = $clog2(N_REGS + 3)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [CFG_WIDTH-1:0]        wr_data,
    input  logic                        rd_valid,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic                        rd_data_valid,
    output logic [CFG_WIDTH-1:0]        rd_data,
    input  logic [N_TILES-1:0]          tile_idle,
    output logic                        quiesce_req,
    output logic [N_REGS*CFG_WIDTH-1:0] cfg_active,
    output logic                        cfg_update,
    output logic [EPOCH_WIDTH-1:0]      cfg_epoch,
    output logic                        busy,
    output logic                        error
);

    localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'(N_REGS + CFG_CTRL_OFS);
    localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(N_REGS + CFG_STATUS_OFS);
    localparam logic [ADDR_W-1:0] VER_A = ADDR_W'(N_REGS + CFG_VERSION_OFS);

    cfg_state_t           state_q;
    cfg_state_t           state_d;
    logic [CFG_WIDTH-1:0] shadow_q [N_REGS];
    logic [CFG_WIDTH-1:0] shadow_d [N_REGS];
    logic [CFG_WIDTH-1:0] active_q [N_REGS];
    logic [CFG_WIDTH-1:0] active_d [N_REGS];
    logic [EPOCH_WIDTH-1:0] epoch_q;
    logic [EPOCH_WIDTH-1:0] epoch_d;
    logic                 error_q;
    logic                 error_d;
    logic                 qreq_q;
    logic                 qreq_d;
    logic                 upd_q;
    logic                 upd_d;
    logic                 rdv_q;
    logic                 rdv_d;
    logic [CFG_WIDTH-1:0] rdd_q;
    logic [CFG_WIDTH-1:0] rdd_d;
    logic [CFG_WIDTH-1:0] rd_mux;

    logic wr_fire;
    logic ctrl_wr;
    logic commit;
    logic abort;
    logic clr_err;
    logic set_err;
    logic apply;
    logic q_en;
    logic q_clr;
    logic stable;
    logic timeout;

    assign wr_ready = (state_q == CFG_IDLE) || (state_q == CFG_QUIESCE);
    assign busy = (state_q != CFG_IDLE);
    assign q_en = (state_q == CFG_QUIESCE);

    cfg_quiesce_ctr #(
        .N_TILES(N_TILES),
        .TIMEOUT(QUIESCE_TIMEOUT)
    ) u_qctr (
        .clk      (clk),
        .rst      (rst),
        .tile_idle(tile_idle),
        .en       (q_en),
        .clr      (q_clr),
        .stable   (stable),
        .timeout  (timeout)
    );

    always_comb begin
        wr_fire = wr_valid && wr_ready;
        ctrl_wr = wr_fire && (wr_addr == CTRL_A);
        abort = ctrl_wr && wr_data[CFG_CTRL_ABORT];
        commit = ctrl_wr && wr_data[CFG_CTRL_COMMIT] && !abort;
        clr_err = ctrl_wr && wr_data[CFG_CTRL_CLR_ERR];
        state_d = state_q;
        q_clr = 1'b0;
        apply = 1'b0;
        set_err = 1'b0;
        unique case (state_q)
            CFG_IDLE: begin
                if (commit) begin
                    state_d = CFG_QUIESCE;
                    q_clr = 1'b1;
                end
            end
            CFG_QUIESCE: begin
                if (abort) begin
                    state_d = CFG_IDLE;
                end else if (stable) begin
                    state_d = CFG_APPLY;
                end else if (timeout) begin
                    state_d = CFG_IDLE;
                    set_err = 1'b1;
                end
            end
            CFG_APPLY: begin
                state_d = CFG_RELEASE;
                apply = 1'b1;
            end
            CFG_RELEASE: state_d = CFG_IDLE;
            default: state_d = CFG_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < N_REGS; i++) begin
            shadow_d[i] = shadow_q[i];
            if (wr_fire && (wr_addr == ADDR_W'(i))) begin
                shadow_d[i] = wr_data;
            end
            active_d[i] = apply ? shadow_q[i] : active_q[i];
        end
        epoch_d = epoch_q + EPOCH_WIDTH'(apply);
        // a timeout in the same cycle as clear-error still leaves error set
        error_d = (error_q && !clr_err) || set_err;
        qreq_d = (state_d != CFG_IDLE);
        upd_d = apply;
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_mux = shadow_q[i];
            end
        end
        if (rd_addr == STAT_A) begin
            rd_mux = CFG_WIDTH'({error_q, state_q, epoch_q});
        end
        if (rd_addr == VER_A) begin
            rd_mux = CFG_WIDTH'(VERSION);
        end
        rdv_d = rd_valid;
        rdd_d = rd_valid ? rd_mux : rdd_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CFG_IDLE;
            for (int i = 0; i < N_REGS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            epoch_q <= '0;
            error_q <= 1'b0;
            qreq_q <= 1'b0;
            upd_q <= 1'b0;
            rdv_q <= 1'b0;
            rdd_q <= '0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < N_REGS; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
            epoch_q <= epoch_d;
            error_q <= error_d;
            qreq_q <= qreq_d;
            upd_q <= upd_d;
            rdv_q <= rdv_d;
            rdd_q <= rdd_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N_REGS; i++) begin
            cfg_active[i*CFG_WIDTH +: CFG_WIDTH] = active_q[i];
        end
    end

    assign rd_data_valid = rdv_q;
    assign rd_data = rdd_q;
    assign quiesce_req = qreq_q;
    assign cfg_update = upd_q;
    assign cfg_epoch = epoch_q;
    assign error = error_q;

endmodule
